// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-8 registered demultiplexer.
package demux_pkg;

  localparam int unsigned DEMUX_SEL_W   = 3;
  localparam int unsigned DEMUX_NUM_OUT = 8;

  typedef logic [DEMUX_SEL_W-1:0]   demux_sel_t;
  typedef logic [DEMUX_NUM_OUT-1:0] demux_vec_t;

endpackage

// File: rtl/demux_1x8_if.sv
// Routing bus for demux_1x8: the producer drives in/sel, the demux drives y0..y7.
interface demux_1x8_if;
  import demux_pkg::*;

  logic       in;
  demux_sel_t sel;
  logic       y0;
  logic       y1;
  logic       y2;
  logic       y3;
  logic       y4;
  logic       y5;
  logic       y6;
  logic       y7;

  modport master (
    output in, sel,
    input  y0, y1, y2, y3, y4, y5, y6, y7
  );

  modport slave (
    input  in, sel,
    output y0, y1, y2, y3, y4, y5, y6, y7
  );

endinterface

// File: rtl/decoder_3to8.sv
// Combinational 3-to-8 one-hot decoder; an unknown select decodes to all zeros.
module decoder_3to8
  import demux_pkg::*;
(
  input  demux_sel_t sel_i,
  output demux_vec_t d_o
);

  // Explicit per-code arms so a non-binary select falls into the default.
  always_comb begin
    d_o = '0;
    case (sel_i)
      3'b000:  d_o = 8'b0000_0001;
      3'b001:  d_o = 8'b0000_0010;
      3'b010:  d_o = 8'b0000_0100;
      3'b011:  d_o = 8'b0000_1000;
      3'b100:  d_o = 8'b0001_0000;
      3'b101:  d_o = 8'b0010_0000;
      3'b110:  d_o = 8'b0100_0000;
      3'b111:  d_o = 8'b1000_0000;
      default: d_o = '0;
    endcase
  end

endmodule

// File: rtl/demux_1x8.sv
// Registered 1-to-8 demultiplexer: steers one bit to the selected output, one-cycle latency.
module demux_1x8
  import demux_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  demux_1x8_if.slave  bus_if
);

  demux_vec_t dec;
  demux_vec_t y_d;
  demux_vec_t y_q;

  decoder_3to8 u_decoder (
    .sel_i (bus_if.sel),
    .d_o   (dec)
  );

  always_comb begin
    y_d = {DEMUX_NUM_OUT{bus_if.in}} & dec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  assign bus_if.y0 = y_q[0];
  assign bus_if.y1 = y_q[1];
  assign bus_if.y2 = y_q[2];
  assign bus_if.y3 = y_q[3];
  assign bus_if.y4 = y_q[4];
  assign bus_if.y5 = y_q[5];
  assign bus_if.y6 = y_q[6];
  assign bus_if.y7 = y_q[7];

endmodule

// File: tb/tb_demux_1x8.sv
// Self-checking bench for demux_1x8: directed scenarios then random routing against a reference model.
module tb_demux_1x8;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [7:0] exp_q;

  demux_1x8_if dif ();

  demux_1x8 dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {dif.y7, dif.y6, dif.y5, dif.y4, dif.y3, dif.y2, dif.y1, dif.y0};
  endfunction

  // Reference: a reset clears everything, otherwise only output number sel may carry in.
  function automatic logic [7:0] model(input logic r, input logic i, input int unsigned s);
    logic [7:0] v;
    v = 8'h00;
    if (!r && i) v[s] = 1'b1;
    return v;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Drive after an edge, confirm outputs hold mid-cycle, then check the post-edge value.
  task automatic step(input string tag, input logic r, input logic i, input int unsigned s);
    logic [7:0] ov;
    rst     = r;
    dif.in  = i;
    dif.sel = 3'(s);
    #2;
    check({tag, "_hold"}, outs(), exp_q);
    exp_q = model(r, i, s);
    @(posedge clk);
    #1;
    ov = outs();
    check(tag, ov, exp_q);
    checks++;
    assert ($countones(ov) <= 1) else begin
      failures++;
      $error("FAIL %s_onehot observed=%b expected=at_most_one_set", tag, ov);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_q    = 8'h00;
    rst      = 1'b1;
    dif.in   = 1'b1;
    dif.sel  = 3'd3;
    @(posedge clk);
    #1;

    step("reset_a", 1'b1, 1'b1, 3);
    step("reset_b", 1'b1, 1'b1, 3);
    step("reset_release", 1'b0, 1'b1, 3);

    for (int s = 0; s < 8; s++) step("in0_sweep", 1'b0, 1'b0, s);
    for (int s = 0; s < 8; s++) step("in1_sweep", 1'b0, 1'b1, s);

    step("simul_pre", 1'b0, 1'b1, 2);
    step("simul_chg", 1'b0, 1'b0, 6);

    step("mid_rst_pre", 1'b0, 1'b1, 7);
    step("mid_rst_on", 1'b1, 1'b1, 7);
    step("mid_rst_off", 1'b0, 1'b1, 7);

    step("lat_pre", 1'b0, 1'b1, 1);
    step("lat_chg", 1'b0, 1'b1, 4);

    for (int n = 0; n < 60; n++) begin
      step("random", ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
           $urandom_range(0, 7));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
